// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK counter bank and its cells.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK   = 2'b00;
    localparam mode_t MODE_UP   = 2'b01;
    localparam mode_t MODE_DOWN = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with clock enable and a per-instance reset value.
module jk_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic reset_val,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= reset_val;
        end else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    // Derived from the flop so it can never disagree with q, even in reset.
    assign q_bar = ~q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit register of JK cells: per-bit JK, up/down count, or parallel load.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    mode_t            mode_sel;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             hold_cnt;

    assign mode_sel = mode_t'(mode);

    // Prefix-AND chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic run_up;
        logic run_dn;
        run_up = 1'b1;
        run_dn = 1'b1;
        up_t   = '0;
        dn_t   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = run_up;
            dn_t[i] = run_dn;
            run_up  = run_up & q[i];
            run_dn  = run_dn & ~q[i];
        end
    end

    assign tc = ((mode_sel == MODE_UP) && (&q)) ||
                ((mode_sel == MODE_DOWN) && (~|q));

    assign hold_cnt = SATURATE && tc;

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode_sel)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_UP: begin
                cell_j = hold_cnt ? '0 : up_t;
                cell_k = hold_cnt ? '0 : up_t;
            end
            MODE_DOWN: begin
                cell_j = hold_cnt ? '0 : dn_t;
                cell_k = hold_cnt ? '0 : dn_t;
            end
            MODE_LOAD: begin
                cell_j = load_val;
                cell_k = ~load_val;
            end
            default: begin
                cell_j = '0;
                cell_k = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk       (clk),
            .reset_n   (reset_n),
            .en        (en),
            .j         (cell_j[gi]),
            .k         (cell_k[gi]),
            .reset_val (RESET_VAL[gi]),
            .q         (q[gi]),
            .q_bar     (q_bar[gi])
        );
    end

    // A counting edge taken at the terminal count wraps q unless saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= en && tc && !SATURATE;
        end
    end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Bench for jk_counter_bank: wrapping, saturating and 1-bit instances share stimulus.
module tb_jk_counter_bank;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] load_val;

    logic [3:0] q0, qb0, q1, qb1;
    logic       tc0, wr0, tc1, wr1;
    logic       q2, qb2, tc2, wr2;

    jk_counter_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q0), .q_bar(qb0), .tc(tc0), .wrap(wr0)
    );

    jk_counter_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q1), .q_bar(qb1), .tc(tc1), .wrap(wr1)
    );

    jk_counter_bank #(.WIDTH(1), .RESET_VAL(1'b1), .SATURATE(1'b0)) dut_one (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .j(j[0]), .k(k[0]),
        .load_val(load_val[0]), .q(q2), .q_bar(qb2), .tc(tc2), .wrap(wr2)
    );

    typedef struct packed {
        logic [2:0][3:0] q;
        logic [2:0]      wrap;
        logic [2:0]      tc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned mq[3];
    int          wd[3]  = '{4, 4, 1};
    bit          sat[3] = '{1'b0, 1'b1, 1'b0};
    int unsigned rv[3]  = '{0, 0, 1};
    int          n_tests = 0;
    int          n_fail  = 0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mask_of(input int d);
        return 4'((1 << wd[d]) - 1);
    endfunction

    // Reference model: integer arithmetic on the register value.
    task automatic step(input bit e, input logic [1:0] md, input logic [3:0] jv,
                        input logic [3:0] kv, input logic [3:0] lv);
        exp_t x;
        en = e; mode = md; j = jv; k = kv; load_val = lv;
        x = '0;
        for (int d = 0; d < 3; d++) begin
            int unsigned mx;
            int unsigned nq;
            bit          w;
            mx = (1 << wd[d]) - 1;
            nq = mq[d];
            w  = 1'b0;
            if (e) begin
                case (md)
                    2'b00: begin
                        for (int b = 0; b < wd[d]; b++) begin
                            if (jv[b] && kv[b]) nq = nq ^ (1 << b);
                            else if (jv[b])     nq = nq | (1 << b);
                            else if (kv[b])     nq = nq & ~(1 << b);
                        end
                    end
                    2'b01: begin
                        if (mq[d] == mx) begin
                            nq = sat[d] ? mx : 0;
                            w  = !sat[d];
                        end else nq = mq[d] + 1;
                    end
                    2'b10: begin
                        if (mq[d] == 0) begin
                            nq = sat[d] ? 0 : mx;
                            w  = !sat[d];
                        end else nq = mq[d] - 1;
                    end
                    default: nq = lv & mx;
                endcase
            end
            mq[d]      = nq;
            x.q[d]     = 4'(nq);
            x.wrap[d]  = w;
            x.tc[d]    = (md == 2'b01 && nq == mx) || (md == 2'b10 && nq == 0);
        end
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_q0"},    q0,  4'(rv[0]));
        check({tag, "_qb0"},   qb0, ~4'(rv[0]) & mask_of(0));
        check({tag, "_wrap0"}, {3'b0, wr0}, 4'b0);
        check({tag, "_q1"},    q1,  4'(rv[1]));
        check({tag, "_qb1"},   qb1, ~4'(rv[1]) & mask_of(1));
        check({tag, "_wrap1"}, {3'b0, wr1}, 4'b0);
        check({tag, "_q2"},    {3'b0, q2},  4'(rv[2]));
        check({tag, "_qb2"},   {3'b0, qb2}, ~4'(rv[2]) & mask_of(2));
        check({tag, "_wrap2"}, {3'b0, wr2}, 4'b0);
    endtask

    // Called in the low phase; reset pulse ends before the next rising edge.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_reset_state(tag);
        for (int d = 0; d < 3; d++) mq[d] = rv[d];
        #3;
        reset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per clock edge that had stimulus.
    always @(posedge clk) begin
        exp_t x;
        logic [3:0] aq[3];
        logic [3:0] aqb[3];
        logic [3:0] atc[3];
        logic [3:0] awr[3];
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            aq  = '{q0, q1, {3'b0, q2}};
            aqb = '{qb0, qb1, {3'b0, qb2}};
            atc = '{{3'b0, tc0}, {3'b0, tc1}, {3'b0, tc2}};
            awr = '{{3'b0, wr0}, {3'b0, wr1}, {3'b0, wr2}};
            for (int d = 0; d < 3; d++) begin
                check($sformatf("q[%0d]", d),     aq[d],  x.q[d]);
                check($sformatf("q_bar[%0d]", d), aqb[d], ~x.q[d] & mask_of(d));
                check($sformatf("tc[%0d]", d),    atc[d], {3'b0, x.tc[d]});
                check($sformatf("wrap[%0d]", d),  awr[d], {3'b0, x.wrap[d]});
            end
        end
    end

    initial begin
        reset_n = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; load_val = '0;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state("reset");
        check("reset_tc0", {3'b0, tc0}, 4'b0);
        for (int d = 0; d < 3; d++) mq[d] = rv[d];
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // JK direct
        step(1, 2'b00, 4'b1010, 4'b0000, 4'h0);
        step(1, 2'b00, 4'b1111, 4'b1111, 4'h0);
        step(1, 2'b00, 4'b0000, 4'b0100, 4'h0);
        step(0, 2'b00, 4'b0000, 4'b0000, 4'h0);

        // Up wrap, then down saturate
        step(1, 2'b11, 4'h0, 4'h0, 4'b1110);
        repeat (3) step(1, 2'b01, 4'h0, 4'h0, 4'h0);
        step(1, 2'b11, 4'h0, 4'h0, 4'b0010);
        repeat (4) step(1, 2'b10, 4'h0, 4'h0, 4'h0);

        // Reset mid-count
        step(1, 2'b11, 4'h0, 4'h0, 4'b0101);
        repeat (2) step(1, 2'b01, 4'h0, 4'h0, 4'h0);
        async_reset("midcount");
        repeat (2) step(1, 2'b01, 4'h0, 4'h0, 4'h0);

        // Enable gating at terminal count
        step(1, 2'b11, 4'h0, 4'h0, 4'b1111);
        repeat (3) step(0, 2'b01, 4'h0, 4'h0, 4'h0);
        step(1, 2'b01, 4'h0, 4'h0, 4'h0);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 4'($urandom));
        end
        en = 1'b0;

        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
